paint_grid_ctrl: RTL and testbench

//  Sequencer for the cursor-paint grid. Turns three push buttons into cursor moves and

---
 rtl/paint_grid_pkg.sv | 46 ++++
 rtl/paint_grid_ctrl_btn_debounce.sv | 83 ++++++++
 rtl/paint_grid_ctrl.sv | 178 +++++++++++++++++
 tb/tb_paint_grid_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/paint_grid_pkg.sv
// ============================================================================
// Module : paint_grid_pkg
// Brief  : Shared geometry, FSM state and move encodings for paint_grid_ctrl.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package paint_grid_pkg;

    localparam int HSIZE_DEF = 96;
    localparam int VSIZE_DEF = 54;
    localparam int NCELLS    = HSIZE_DEF * VSIZE_DEF;
    localparam int ROW_W     = $clog2(VSIZE_DEF);
    localparam int COL_W     = $clog2(HSIZE_DEF);
    localparam int ADDR_W    = $clog2(NCELLS);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CHK  = 3'd2,
        ST_WR   = 3'd3,
        ST_CLR  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        MV_NONE  = 2'd0,
        MV_RIGHT = 2'd1,
        MV_UP    = 2'd2,
        MV_DOWN  = 2'd3
    } move_e;

    // Simultaneous edges resolve right > up > down; the losers are discarded.
    function automatic move_e pick_move(input logic [2:0] rise);
        if (rise[0]) begin
            return MV_RIGHT;
        end else if (rise[1]) begin
            return MV_UP;
        end else if (rise[2]) begin
            return MV_DOWN;
        end
        return MV_NONE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/paint_grid_ctrl_btn_debounce.sv
// ============================================================================
// Module : btn_debounce
// Brief  : 2-flop synchroniser, optional debounce (DEBOUNCE_EN), rising-edge pulse.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module btn_debounce
`ifdef DEBOUNCE_EN
#(
    parameter int DEB_CYCLES = 250000
)
`endif
(
    input  logic CLK,
    input  logic RESET,
    input  logic btn_raw,
    output logic btn_rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic level;

`ifdef DEBOUNCE_EN
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;

    // The accepted level flips on the DEB_CYCLES-th consecutive differing sample.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
            cnt_d   = '0;
            level_d = sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
`else
    assign level = sync2_q;
`endif

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        prev_d  = level;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign btn_rise = level & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/paint_grid_ctrl.sv
// ============================================================================
// Module : paint_grid_ctrl
// Brief  : Button-driven cursor painter over a shared 1-bit grid RAM with clear
//          sweep. Optional button debounce built when DEBOUNCE_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module paint_grid_ctrl
    import paint_grid_pkg::*;
#(
    parameter int HSIZE = HSIZE_DEF,
    parameter int VSIZE = VSIZE_DEF
`ifdef DEBOUNCE_EN
    ,
    parameter int DEB_CYCLES = 250000
`endif
)
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic [2:0]        btn,
    input  logic              clr_req,
    input  logic              mem_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wdata,
    input  logic              mem_rdata,
    output logic [ROW_W-1:0]  cur_row,
    output logic [COL_W-1:0]  cur_col,
    output logic [ADDR_W-1:0] cell_cnt,
    output logic              busy
);

    localparam int                NCELLS_P  = HSIZE * VSIZE;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NCELLS_P - 1);
    localparam logic [ADDR_W-1:0] CNT_MAX   = ADDR_W'(NCELLS_P);
    localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(HSIZE - 1);
    localparam logic [ROW_W-1:0]  ROW_MAX   = ROW_W'(VSIZE - 1);

    logic [2:0] rise;

    for (genvar i = 0; i < 3; i++) begin : g_btn
        btn_debounce
`ifdef DEBOUNCE_EN
        #(
            .DEB_CYCLES (DEB_CYCLES)
        )
`endif
        u_deb (
            .CLK      (CLK),
            .RESET    (RESET),
            .btn_raw  (btn[i]),
            .btn_rise (rise[i])
        );
    end

    state_e            state_q,    state_d;
    move_e             pend_q,     pend_d;
    logic [ROW_W-1:0]  row_q,      row_d;
    logic [COL_W-1:0]  col_q,      col_d;
    logic [ADDR_W-1:0] cnt_q,      cnt_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              clr_lat_q,  clr_lat_d;
    logic              run_q,      run_d;
    move_e             new_move;
    logic [ADDR_W-1:0] cur_addr;

    assign new_move = pick_move(rise);
    assign cur_addr = ADDR_W'(row_q) * ADDR_W'(HSIZE) + ADDR_W'(col_q);

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        row_d      = row_q;
        col_d      = col_q;
        cnt_d      = cnt_q;
        clr_addr_d = clr_addr_q;
        clr_lat_d  = clr_lat_q;
        run_d      = 1'b1;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = 1'b0;
        mem_addr   = cur_addr;

        if (pend_q == MV_NONE) begin
            pend_d = new_move;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (clr_req || clr_lat_q) begin
                    state_d    = ST_CLR;
                    clr_addr_d = '0;
                    clr_lat_d  = 1'b0;
                end else if (pend_q != MV_NONE) begin
                    pend_d  = MV_NONE;
                    state_d = ST_RD;
                    case (pend_q)
                        MV_RIGHT: col_d = (col_q == COL_MAX) ? '0 : col_q + 1'b1;
                        MV_UP:    row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
                        MV_DOWN:  row_d = (row_q == '0) ? ROW_MAX : row_q - 1'b1;
                        default:  ;
                    endcase
                end
            end
            ST_RD: begin
                if (clr_req) clr_lat_d = 1'b1;
                if (mem_gnt) begin
                    mem_en  = 1'b1;
                    state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                if (clr_req) clr_lat_d = 1'b1;
                state_d = mem_rdata ? ST_IDLE : ST_WR;
            end
            ST_WR: begin
                if (clr_req) clr_lat_d = 1'b1;
                if (mem_gnt) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_wdata = 1'b1;
                    state_d   = ST_IDLE;
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CLR: begin
                // run_q holds the bus quiet during and for one cycle after reset.
                mem_addr = clr_addr_q;
                if (run_q) begin
                    mem_we = 1'b1;
                    if (mem_gnt) begin
                        mem_en = 1'b1;
                        if (clr_addr_q == LAST_ADDR) begin
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            clr_addr_d = clr_addr_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_CLR;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_CLR;
            pend_q     <= MV_NONE;
            row_q      <= '0;
            col_q      <= '0;
            cnt_q      <= '0;
            clr_addr_q <= '0;
            clr_lat_q  <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            row_q      <= row_d;
            col_q      <= col_d;
            cnt_q      <= cnt_d;
            clr_addr_q <= clr_addr_d;
            clr_lat_q  <= clr_lat_d;
            run_q      <= run_d;
        end
    end

    assign cur_row  = row_q;
    assign cur_col  = col_q;
    assign cell_cnt = cnt_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_paint_grid_ctrl.sv
// ============================================================================
// Module : tb_paint_grid_ctrl
// Brief  : Scoreboard bench for paint_grid_ctrl against a grid-level model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_paint_grid_ctrl;

    localparam int HS   = 96;
    localparam int VS   = 54;
    localparam int NC   = HS * VS;
    localparam int HOLD = 10;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [2:0]  btn = 3'b000;
    logic        clr_req = 1'b0;
    logic        mem_gnt = 1'b1;
    logic        mem_rdata = 1'b0;
    logic        mem_en, mem_we, mem_wdata, busy;
    logic [12:0] mem_addr, cell_cnt;
    logic [5:0]  cur_row;
    logic [6:0]  cur_col;

    paint_grid_ctrl #(
        .HSIZE (HS),
        .VSIZE (VS)
`ifdef DEBOUNCE_EN
        ,
        .DEB_CYCLES (4)
`endif
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .btn       (btn),
        .clr_req   (clr_req),
        .mem_gnt   (mem_gnt),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .cur_row   (cur_row),
        .cur_col   (cur_col),
        .cell_cnt  (cell_cnt),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        we;
        logic [12:0] addr;
        logic        wd;
    } txn_t;

    txn_t exp_q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   n_strobe = 0;
    bit   ram[NC];
    bit   painted[NC];
    int   m_row = 0;
    int   m_col = 0;
    int   m_cnt = 0;
    bit   gnt_rand = 1'b0;
    bit   gnt_val  = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Grid-level model: a sweep zeroes every cell in address order.
    task automatic push_sweep();
        for (int i = 0; i < NC; i++) begin
            exp_q.push_back('{we: 1'b1, addr: 13'(i), wd: 1'b0});
            painted[i] = 1'b0;
        end
        m_cnt = 0;
    endtask

    task automatic model_move(input logic [2:0] mask);
        int a;
        if (mask[0])      m_col = (m_col + 1) % HS;
        else if (mask[1]) m_row = (m_row + 1) % VS;
        else if (mask[2]) m_row = (m_row + VS - 1) % VS;
        a = m_row * HS + m_col;
        exp_q.push_back('{we: 1'b0, addr: 13'(a), wd: 1'b0});
        if (!painted[a]) begin
            exp_q.push_back('{we: 1'b1, addr: 13'(a), wd: 1'b1});
            painted[a] = 1'b1;
            if (m_cnt < NC) m_cnt++;
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || busy) && k < budget) begin
            cyc(1);
            k++;
        end
        check({name, "_finished_in_budget"}, (k < budget), 1);
        if (k >= budget) exp_q.delete();
    endtask

    task automatic check_state(input string name);
        check({name, "_row"},  cur_row,  m_row);
        check({name, "_col"},  cur_col,  m_col);
        check({name, "_cnt"},  cell_cnt, m_cnt);
        check({name, "_busy"}, busy,     0);
    endtask

    task automatic press(input logic [2:0] mask);
        model_move(mask);
        btn = mask;
        cyc(HOLD);
        btn = 3'b000;
        wait_done("press", 3000);
        cyc(HOLD);
        check_state("press");
    endtask

    task automatic do_reset(input string name);
        RESET = 1'b1;
        btn   = 3'b000;
        exp_q.delete();
        cyc(3);
        @(negedge CLK);
        check({name, "_rst_busy"},  busy,      1);
        check({name, "_rst_en"},    mem_en,    0);
        check({name, "_rst_we"},    mem_we,    0);
        check({name, "_rst_addr"},  mem_addr,  0);
        check({name, "_rst_wdata"}, mem_wdata, 0);
        check({name, "_rst_row"},   cur_row,   0);
        check({name, "_rst_col"},   cur_col,   0);
        check({name, "_rst_cnt"},   cell_cnt,  0);
        cyc(1);
        RESET = 1'b0;
        m_row = 0;
        m_col = 0;
        push_sweep();
        wait_done({name, "_sweep"}, 25000);
        check_state({name, "_after_sweep"});
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            #2;
            mem_gnt = gnt_rand ? ($urandom_range(0, 3) != 0) : gnt_val;
        end
    end

    // Monitor: RAM behaviour plus scoreboard comparison of every strobe.
    initial begin
        txn_t t;
        forever begin
            @(negedge CLK);
            if (!RESET && mem_en === 1'b1) begin
                n_strobe++;
                check("en_only_with_gnt", mem_gnt, 1);
                if (mem_addr < NC) begin
                    if (mem_we) ram[mem_addr] = mem_wdata;
                    else        mem_rdata     = ram[mem_addr];
                end
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got we=%0d addr=%0d wdata=%0d, expected none",
                             mem_we, mem_addr, mem_wdata);
                end else begin
                    t = exp_q.pop_front();
                    check("strobe_we",   mem_we,   t.we);
                    check("strobe_addr", mem_addr, t.addr);
                    if (t.we) check("strobe_wdata", mem_wdata, t.wd);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        for (int i = 0; i < NC; i++) ram[i] = 1'($urandom_range(0, 1));

        do_reset("por");

        press(3'b001);
        press(3'b100);
        check("down_wrap_row", cur_row, 53);
        repeat (HS) press(3'b001);
        check("col_full_wrap", cur_col, 1);
        press(3'b010);
        press(3'b100);

        // Grant withheld while in RD: no strobe until the first granted cycle.
        gnt_val = 1'b0;
        model_move(3'b001);
        base = n_strobe;
        btn = 3'b001;
        cyc(HOLD);
        btn = 3'b000;
        cyc(20);
        check("no_strobe_while_gnt_low", n_strobe, base);
        check("busy_while_gnt_low", busy, 1);
        gnt_val = 1'b1;
        cyc(1);
        @(negedge CLK);
        #1;
        check("read_on_first_gnt", n_strobe, base + 1);
        wait_done("gnt_low", 3000);
        cyc(HOLD);
        check_state("gnt_low");

        // clr_req during CHK/WR: paint completes, then a full sweep.
        model_move(3'b001);
        push_sweep();
        base = n_strobe;
        btn = 3'b001;
        k = 0;
        while (n_strobe == base && k < 100) begin
            cyc(1);
            k++;
        end
        check("read_seen_before_clr", (k < 100), 1);
        clr_req = 1'b1;
        cyc(2);
        clr_req = 1'b0;
        cyc(HOLD);
        btn = 3'b000;
        wait_done("clr_during_wr", 25000);
        cyc(HOLD);
        check_state("clr_during_wr");

        press(3'b011);
        press(3'b110);
        press(3'b111);

`ifdef DEBOUNCE_EN
        base = n_strobe;
        btn = 3'b001;
        cyc(2);
        btn = 3'b000;
        cyc(30);
        check("glitch_no_strobe", n_strobe, base);
        check_state("glitch");
`endif

        gnt_rand = 1'b1;
        repeat (40) press(3'($urandom_range(1, 7)));
        gnt_rand = 1'b0;

        // Reset in the middle of a sweep restarts it from address 0.
        push_sweep();
        clr_req = 1'b1;
        cyc(1);
        clr_req = 1'b0;
        cyc(100);
        check("sweep_in_progress", busy, 1);
        do_reset("mid_sweep");
        press(3'b001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
